// File: rtl/column_renderer.sv
// Column renderer: turns one raytraced column result (wall height, colour,
// hit face) into SCREEN_H vertical pixel writes for the VGA adapter, for
// SCREEN_W columns per frame. Ceiling above the wall slice, floor below it.
//
// Optional build macro: COLUMN_SHADE_EN
//   When defined, wall pixels hit on a y-face (col_side = 1) are dithered to
//   black on odd (x + y) to give a cheap shading cue. When undefined, the
//   hit face is ignored.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | waiting for a start pulse; all outputs quiet
// WAIT_COL | col_ready high, waiting for the next column result
// DRAW     | one pixel per cycle, rows 0 .. SCREEN_H-1 of the current column
// DONE     | one-cycle done pulse after the final pixel of the frame
module column_renderer #(
  parameter int         SCREEN_W     = 160,
  parameter int         SCREEN_H     = 120,
  parameter logic [2:0] CEIL_COLOUR  = 3'b001,
  parameter logic [2:0] FLOOR_COLOUR = 3'b010
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  output logic       done,
  input  logic       col_valid,
  output logic       col_ready,
  input  logic [6:0] col_height,
  input  logic [2:0] col_colour,
  input  logic       col_side,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_write
);

  localparam logic [6:0] ROW_LAST = 7'(SCREEN_H - 1);
  localparam logic [7:0] COL_LAST = 8'(SCREEN_W - 1);
  localparam logic [6:0] H_MAX    = 7'(SCREEN_H);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_COL = 2'd1,
    DRAW     = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t     state;
  state_t     state_nxt;

  logic [7:0] col_cnt;
  logic [6:0] row_cnt;
  logic [6:0] wall_h;
  logic [6:0] wall_top;
  logic [2:0] wall_colour;

  // control strobes from the FSM to the datapath
  logic       col_clear;
  logic       col_inc;
  logic       capture;
  logic       row_inc;

  logic [6:0] h_clamped;
  logic [6:0] top_calc;
  logic [7:0] wall_end;
  logic       in_wall;
  logic       shade_px;
  logic [2:0] pix_colour;

`ifdef COLUMN_SHADE_EN
  logic       wall_side;
`else
  logic       unused_col_side;
  assign unused_col_side = col_side;
`endif

  // Clamp the incoming height and derive the centred wall top for capture.
  always_comb begin
    h_clamped = col_height;
    if (col_height > H_MAX) begin
      h_clamped = H_MAX;
    end
    top_calc = (H_MAX - h_clamped) >> 1;
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and datapath control strobes.
  always_comb begin
    state_nxt = state;
    col_clear = 1'b0;
    col_inc   = 1'b0;
    capture   = 1'b0;
    row_inc   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          col_clear = 1'b1;
          state_nxt = WAIT_COL;
        end
      end
      WAIT_COL: begin
        if (col_valid) begin
          capture   = 1'b1;
          state_nxt = DRAW;
        end
      end
      DRAW: begin
        row_inc = 1'b1;
        if (row_cnt == ROW_LAST) begin
          if (col_cnt == COL_LAST) begin
            state_nxt = DONE;
          end else begin
            col_inc   = 1'b1;
            state_nxt = WAIT_COL;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Column/row counters and the captured column result.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      col_cnt     <= '0;
      row_cnt     <= '0;
      wall_h      <= '0;
      wall_top    <= '0;
      wall_colour <= '0;
    end else begin
      if (col_clear) begin
        col_cnt <= '0;
      end else if (col_inc) begin
        col_cnt <= col_cnt + 8'd1;
      end
      if (capture) begin
        row_cnt     <= '0;
        wall_h      <= h_clamped;
        wall_top    <= top_calc;
        wall_colour <= col_colour;
      end else if (row_inc) begin
        row_cnt <= row_cnt + 7'd1;
      end
    end
  end

`ifdef COLUMN_SHADE_EN
  // Hit face for the dither shading, captured with the rest of the column.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wall_side <= 1'b0;
    end else if (capture) begin
      wall_side <= col_side;
    end
  end
`endif

  // Pixel colour for the current row: ceiling, wall slice, or floor.
  always_comb begin
    // widened so top + h never wraps even at the maximum height
    wall_end = {1'b0, wall_top} + {1'b0, wall_h};
    in_wall  = (row_cnt >= wall_top) && ({1'b0, row_cnt} < wall_end);
`ifdef COLUMN_SHADE_EN
    shade_px = wall_side && (col_cnt[0] ^ row_cnt[0]);
`else
    shade_px = 1'b0;
`endif
    if (row_cnt < wall_top) begin
      pix_colour = CEIL_COLOUR;
    end else if (in_wall) begin
      pix_colour = shade_px ? 3'b000 : wall_colour;
    end else begin
      pix_colour = FLOOR_COLOUR;
    end
  end

  // Outputs decode straight from the state so reset quiets them at once.
  always_comb begin
    done       = 1'b0;
    col_ready  = 1'b0;
    vga_write  = 1'b0;
    vga_x      = '0;
    vga_y      = '0;
    vga_colour = '0;
    unique case (state)
      WAIT_COL: col_ready = 1'b1;
      DRAW: begin
        vga_write  = 1'b1;
        vga_x      = col_cnt;
        vga_y      = row_cnt;
        vga_colour = pix_colour;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

endmodule
